// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control sequencer:
// opcodes, FSM states, datapath select codes and instruction classes.
package mc_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_ADDR, S_MEM_RD,
    S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_SLTU = 3'd3,
    ALU_SLL = 3'd4, ALU_LUI = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JTGT, PC_RS} pc_src_t;
  typedef enum logic [1:0] {SRCB_RT, SRCB_FOUR, SRCB_IMM, SRCB_IMM_SH2} alu_src_b_t;
  typedef enum logic [1:0] {RD_RT, RD_RD, RD_RA} reg_dst_t;
  typedef enum logic [1:0] {M2R_ALU, M2R_MDR, M2R_PC} mem_to_reg_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_IMM, CLS_BEQ, CLS_LOAD, CLS_STORE, CLS_JR, CLS_JUMP, CLS_JAL,
    CLS_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic        sel;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    pc_src_t     pc_src;
    logic        src_a;
    alu_src_b_t  src_b;
    logic        ext;
    alu_op_t     alu_op;
    reg_dst_t    reg_dst;
    mem_to_reg_t m2r;
    logic        illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Unified instruction/data memory request/ready handshake.
interface mc_ctrl_if;
  logic req;
  logic we;
  logic sel;
  logic ready;

  modport master (output req, we, sel, input ready);
  modport slave  (input req, we, sel, output ready);
endinterface

// File: rtl/mc_ctrl_instr_class.sv
// Combinational opcode/funct classifier feeding the sequencer.
module instr_class
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output iclass_t    cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_JR:                   cls = CLS_JR;
          FN_ADDU, FN_SUBU, FN_SLL: cls = CLS_R;
          default:                 cls = CLS_ILLEGAL;
        endcase
      end
      OP_ORI, OP_LUI, OP_SLTIU: cls = CLS_IMM;
      OP_LW:                    cls = CLS_LOAD;
      OP_SW:                    cls = CLS_STORE;
      OP_BEQ:                   cls = CLS_BEQ;
      OP_J:                     cls = CLS_JUMP;
      OP_JAL:                   cls = CLS_JAL;
      default:                  cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: Moore-decoded datapath selects, memory handshake,
// sticky illegal trap and retired-instruction counter.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  mc_ctrl_if.master   mem,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_op,
  output logic [2:0]  alu_op,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        illegal,
  output logic [31:0] retired
);

  state_t      state, nxt;
  iclass_t     cls;
  ctrl_t       c, co;
  logic        retire;
  logic [31:0] retired_q;
  logic        unused_instr;

  assign unused_instr = ^instr[25:6];

  instr_class u_cls (.op(instr[31:26]), .fn(instr[5:0]), .cls(cls));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      retired_q <= '0;
    end else begin
      state <= nxt;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    nxt    = state;
    c      = '0;
    retire = 1'b0;
    case (state)
      S_FETCH: begin
        c.req   = 1'b1;
        c.src_b = SRCB_FOUR;
        if (mem.ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          nxt        = S_DECODE;
        end
      end
      // ALUOut captures PC+4 + (sext(imm)<<2) for a possible beq.
      S_DECODE: begin
        c.src_b = SRCB_IMM_SH2;
        c.ext   = 1'b1;
        case (cls)
          CLS_JR:               nxt = S_JR;
          CLS_R:                nxt = S_EXEC_R;
          CLS_IMM:              nxt = S_EXEC_I;
          CLS_LOAD, CLS_STORE:  nxt = S_ADDR;
          CLS_BEQ:              nxt = S_BRANCH;
          CLS_JUMP, CLS_JAL:    nxt = S_JUMP;
          default:              nxt = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        c.src_a = 1'b1;
        c.src_b = SRCB_RT;
        case (instr[5:0])
          FN_SUBU: c.alu_op = ALU_SUB;
          FN_SLL:  c.alu_op = ALU_SLL;
          default: c.alu_op = ALU_ADD;
        endcase
        nxt = S_WB_ALU;
      end
      S_EXEC_I: begin
        c.src_a = 1'b1;
        c.src_b = SRCB_IMM;
        case (instr[31:26])
          OP_ORI:   c.alu_op = ALU_OR;
          OP_LUI:   c.alu_op = ALU_LUI;
          default: begin
            c.ext    = 1'b1;
            c.alu_op = ALU_SLTU;
          end
        endcase
        nxt = S_WB_ALU;
      end
      S_WB_ALU: begin
        c.reg_write = 1'b1;
        c.reg_dst   = (cls == CLS_R) ? RD_RD : RD_RT;
        retire      = 1'b1;
        nxt         = S_FETCH;
      end
      S_ADDR: begin
        c.src_a = 1'b1;
        c.src_b = SRCB_IMM;
        c.ext   = 1'b1;
        nxt     = (cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        c.req = 1'b1;
        c.sel = 1'b1;
        if (mem.ready) nxt = S_WB_MEM;
      end
      S_WB_MEM: begin
        c.reg_write = 1'b1;
        c.m2r       = M2R_MDR;
        retire      = 1'b1;
        nxt         = S_FETCH;
      end
      S_MEM_WR: begin
        c.req = 1'b1;
        c.we  = 1'b1;
        c.sel = 1'b1;
        if (mem.ready) begin
          retire = 1'b1;
          nxt    = S_FETCH;
        end
      end
      S_BRANCH: begin
        c.src_a    = 1'b1;
        c.src_b    = SRCB_RT;
        c.alu_op   = ALU_SUB;
        c.pc_src   = PC_ALUOUT;
        c.pc_write = alu_zero;
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      // PC was already advanced in FETCH, so it is the jal link value.
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_JTGT;
        if (cls == CLS_JAL) begin
          c.reg_write = 1'b1;
          c.reg_dst   = RD_RA;
          c.m2r       = M2R_PC;
        end
        retire = 1'b1;
        nxt    = S_FETCH;
      end
      S_JR: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_RS;
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
        nxt       = S_TRAP;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Reset gates every output, so the FETCH request drops asynchronously.
  assign co = rst_n ? c : '0;

  assign mem.req    = co.req;
  assign mem.we     = co.we;
  assign mem.sel    = co.sel;
  assign ir_write   = co.ir_write;
  assign pc_write   = co.pc_write;
  assign reg_write  = co.reg_write;
  assign pc_src     = co.pc_src;
  assign alu_src_a  = co.src_a;
  assign alu_src_b  = co.src_b;
  assign ext_op     = co.ext;
  assign alu_op     = co.alu_op;
  assign reg_dst    = co.reg_dst;
  assign mem_to_reg = co.m2r;
  assign illegal    = co.illegal;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: an instruction-level model lists the expected
// per-cycle control vector, and one compare process checks it every cycle.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, reg_write, alu_src_a, ext_op, illegal;
  logic [1:0]  pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0]  alu_op;
  logic [31:0] retired;

  mc_ctrl_if mem ();
  assign mem.ready = mem_ready;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero), .mem(mem),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, OR = 3'd2, SLTU = 3'd3,
                         SLL = 3'd4, LUI = 3'd5;

  logic [19:0] dut_vec, exp_vec;
  assign dut_vec = {mem.req, mem.we, mem.sel, ir_write, pc_write, reg_write,
                    pc_src, alu_src_a, alu_src_b, ext_op, alu_op, reg_dst,
                    mem_to_reg, illegal};

  int          checks = 0, failures = 0;
  logic        chk = 1'b0;
  logic [31:0] ret_m = '0;
  int          ncyc = 0, req_cnt = 0;

  function automatic logic [19:0] mk(input logic req, we, sel, irw, pcw, rw,
                                     input logic [1:0] pcs, input logic sa,
                                     input logic [1:0] sb, input logic ext,
                                     input logic [2:0] aop,
                                     input logic [1:0] rd, m2r,
                                     input logic ill);
    return {req, we, sel, irw, pcw, rw, pcs, sa, sb, ext, aop, rd, m2r, ill};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("ctrl_vec", {12'd0, dut_vec}, {12'd0, exp_vec});
      check("retired", retired, ret_m);
      if (mem.req && mem.sel) req_cnt++;
    end
  end

  task automatic step(input logic rdy, input logic [19:0] v);
    mem_ready = rdy;
    exp_vec   = v;
    chk       = 1'b1;
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: fw fetch wait cycles, mw data wait cycles.
  task automatic play(input logic [31:0] ins, input logic z, input int fw, input int mw);
    logic [5:0] op, fn;
    logic       trap;
    instr    = ins;
    alu_zero = z;
    op       = ins[31:26];
    fn       = ins[5:0];
    trap     = 1'b0;
    ncyc     = 0;
    for (int i = 0; i < fw; i++) step(1'b0, mk(1,0,0,0,0,0,0,0,1,0,ADD,0,0,0));
    step(1'b1, mk(1,0,0,1,1,0,0,0,1,0,ADD,0,0,0));
    step(1'b1, mk(0,0,0,0,0,0,0,0,3,1,ADD,0,0,0));
    if (op == 6'h00 && fn == 6'h08)
      step(1'b1, mk(0,0,0,0,1,0,3,0,0,0,ADD,0,0,0));
    else if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h00)) begin
      step(1'b1, mk(0,0,0,0,0,0,0,1,0,0,
                    fn == 6'h21 ? ADD : fn == 6'h23 ? SUB : SLL, 0,0,0));
      step(1'b1, mk(0,0,0,0,0,1,0,0,0,0,ADD,1,0,0));
    end else if (op == 6'h0D || op == 6'h0F || op == 6'h0B) begin
      step(1'b1, mk(0,0,0,0,0,0,0,1,2, op == 6'h0B,
                    op == 6'h0D ? OR : op == 6'h0F ? LUI : SLTU, 0,0,0));
      step(1'b1, mk(0,0,0,0,0,1,0,0,0,0,ADD,0,0,0));
    end else if (op == 6'h23 || op == 6'h2B) begin
      step(1'b1, mk(0,0,0,0,0,0,0,1,2,1,ADD,0,0,0));
      for (int i = 0; i <= mw; i++)
        step(i == mw, mk(1, op == 6'h2B, 1,0,0,0,0,0,0,0,ADD,0,0,0));
      if (op == 6'h23) step(1'b1, mk(0,0,0,0,0,1,0,0,0,0,ADD,0,1,0));
    end else if (op == 6'h04)
      step(1'b1, mk(0,0,0,0,z,0,1,1,0,0,SUB,0,0,0));
    else if (op == 6'h02)
      step(1'b1, mk(0,0,0,0,1,0,2,0,0,0,ADD,0,0,0));
    else if (op == 6'h03)
      step(1'b1, mk(0,0,0,0,1,1,2,0,0,0,ADD,2,2,0));
    else begin
      trap = 1'b1;
      for (int i = 0; i < 6; i++)
        step(1'($urandom_range(0, 1)), mk(0,0,0,0,0,0,0,0,0,0,ADD,0,0,1));
    end
    if (!trap) ret_m = ret_m + 32'd1;
  endtask

  task automatic do_reset();
    chk       = 1'b0;
    mem_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("rst_outputs", {12'd0, dut_vec}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_retired", retired, 32'd0);
    check("rst_outputs_held", {12'd0, dut_vec}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ret_m = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    do_reset();

    play(32'h00221821, 1'b0, 0, 0);          // addu
    check("addu_cycles", ncyc, 4);
    check("addu_retired", retired, 32'd1);
    play(32'h00221823, 1'b0, 0, 0);          // subu
    play(32'h00021080, 1'b0, 0, 0);          // sll
    play(32'h34220005, 1'b0, 0, 0);          // ori
    play(32'h3C011234, 1'b0, 0, 0);          // lui
    play(32'h2C22FFFF, 1'b0, 0, 0);          // sltiu
    req_cnt = 0;
    play(32'h8C220004, 1'b0, 0, 3);          // lw, 3 wait cycles
    check("lw_cycles", ncyc, 8);
    check("lw_data_req_cycles", req_cnt, 4);
    play(32'hAC220008, 1'b0, 2, 1);          // sw with fetch and data waits
    check("sw_cycles", ncyc, 7);
    play(32'h10220003, 1'b1, 0, 0);          // beq taken
    check("beq_taken_cycles", ncyc, 3);
    play(32'h10220003, 1'b0, 0, 0);          // beq not taken
    check("beq_nt_cycles", ncyc, 3);
    play(32'h08000004, 1'b0, 0, 0);          // j
    fork
      play(32'h0C000010, 1'b0, 0, 0);        // jal
      begin
        repeat (3) @(negedge clk);
        check("jal_pc_write", pc_write, 1);
        check("jal_pc_src", pc_src, 2);
        check("jal_reg_write", reg_write, 1);
        check("jal_reg_dst", reg_dst, 2);
        check("jal_mem_to_reg", mem_to_reg, 2);
      end
    join
    play(32'h03E00008, 1'b0, 0, 0);          // jr
    check("retired_after_mix", retired, 32'd13);

    play(32'hFC000000, 1'b0, 0, 0);          // opcode 0x3F
    check("trap_illegal", illegal, 1);
    check("trap_retired", retired, 32'd13);
    do_reset();
    check("illegal_cleared", illegal, 0);
    play(32'h0000002A, 1'b0, 0, 0);          // special, funct 0x2A
    check("trap2_illegal", illegal, 1);
    do_reset();
    check("illegal_cleared2", illegal, 0);

    play(32'h00221821, 1'b0, 0, 0);
    instr    = 32'hAC220008;
    alu_zero = 1'b0;
    step(1'b1, mk(1,0,0,1,1,0,0,0,1,0,ADD,0,0,0));
    step(1'b1, mk(0,0,0,0,0,0,0,0,3,1,ADD,0,0,0));
    step(1'b1, mk(0,0,0,0,0,0,0,1,2,1,ADD,0,0,0));
    step(1'b0, mk(1,1,1,0,0,0,0,0,0,0,ADD,0,0,0));
    step(1'b0, mk(1,1,1,0,0,0,0,0,0,0,ADD,0,0,0));
    chk = 1'b0;
    #2;
    check("memwr_req_before_rst", mem.req, 1);
    check("retired_before_rst", retired, 32'd1);
    rst_n = 1'b0;
    #1;
    check("memwr_req_async_drop", mem.req, 0);
    @(posedge clk);
    @(negedge clk);
    check("memwr_rst_retired", retired, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ret_m = '0;
    #1;
    check("first_fetch_req", mem.req, 1);
    #1;
    play(32'h00221821, 1'b0, 0, 0);
    check("retired_after_abort", retired, 32'd1);

    chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS-subset CPU (addu, subu, sll, jr, ori, lui, sltiu, lw, sw, beq, j, jal). It takes the instruction register and ALU zero flag, steps one state machine per instruction, and drives every datapath select and write enable. It also handles a req/ready handshake to the unified instruction/data memory and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction register contents; valid from DECODE onward.
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; valid only with mem_req.
- mem_sel  out  1  address source: 0 = PC, 1 = ALUOut.
- ir_write, pc_write, reg_write  out  1 each  register write enables.
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = {PC[31:28], instr[25:0], 00}, 3 = rs.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  0 = rt, 1 = constant 4, 2 = ext(imm), 3 = ext(imm)<<2.
- ext_op  out  1  0 = zero-extend, 1 = sign-extend.
- alu_op  out  3  0 = ADD, 1 = SUB, 2 = OR, 3 = SLTU, 4 = SLL, 5 = LUI.
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC.
- illegal  out  1  sticky unsupported-opcode/funct flag.
- retired  out  32  retired-instruction count.

## Operation
- State register uses these states: FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, JR, TRAP.
- All outputs are Moore-decoded from state. Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, mem_sel=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0.
  - ir_write and pc_write are asserted only when mem_ready=1; FETCH then moves to DECODE.
  - While mem_ready=0, FETCH holds and all outputs stay constant.
- DECODE: alu_src_a=0, alu_src_b=3, ext_op=1, alu_op=ADD; this computes the branch target into ALUOut.
  - Next state by class:
  - special with funct jr → JR.
  - addu/subu/sll → EXEC_R.
  - ori/lui/sltiu → EXEC_I.
  - lw/sw → ADDR.
  - beq → BRANCH.
  - j/jal → JUMP.
  - Anything else, including an unknown funct under special → TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=0; alu_op is ADD for addu, SUB for subu, SLL for sll. Next is WB_ALU with reg_dst=1.
- EXEC_I: alu_src_a=1, alu_src_b=2.
  - ori: ext_op=0, alu_op=OR.
  - lui: alu_op=LUI (imm<<16).
  - sltiu: ext_op=1, alu_op=SLTU (unsigned compare of the sign-extended immediate).
  - Next is WB_ALU with reg_dst=0.
- WB_ALU: reg_write=1, mem_to_reg=0, reg_dst held from the instruction class → FETCH.
- ADDR: alu_src_a=1, alu_src_b=2, ext_op=1, alu_op=ADD → MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, mem_sel=1; waits for mem_ready → WB_MEM.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEM_WR: mem_req=1, mem_we=1, mem_sel=1; waits for mem_ready → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1; pc_write = alu_zero → FETCH.
- JUMP: pc_write=1, pc_src=2. jal also asserts reg_write=1, reg_dst=2, mem_to_reg=2; PC already holds the return address (PC+4) → FETCH.
- JR: pc_write=1, pc_src=3 → FETCH.
- TRAP: illegal=1 and stays set; the block remains in TRAP until reset. No memory requests, no writes.
- retired increments by 1 on the last cycle of each instruction: WB_ALU, WB_MEM, MEM_WR with mem_ready, BRANCH, JUMP, JR. It wraps 0xFFFFFFFF→0 and never increments in TRAP.

## Timing
- Reset: state=FETCH, illegal=0, retired=0.
  - While rst_n=0, all outputs are forced to 0, mem_req included.
  - The first FETCH request appears in the first cycle with rst_n=1.
- Cycle counts with zero-wait memory (mem_ready high in the first request cycle):
  - beq, j, jal, jr: 3 cycles.
  - R-type, I-type, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- Handshake: mem_req, mem_we and mem_sel stay stable until the cycle mem_ready=1. mem_ready while mem_req=0 is ignored.
- Reset asserted mid-access drops mem_req immediately (asynchronously). Nothing is retired for the aborted instruction.

## Structure
- The shared package `mc_pkg` holds:
  - opcode/funct constants;
  - state encoding (4-bit);
  - alu_op, pc_src, alu_src_b, reg_dst and mem_to_reg encodings.
- Sub-module `instr_class` is combinational and maps instr[31:26]/[5:0] to a class code (R, IMM, BEQ, LOAD, STORE, JR, JUMP, JAL, ILLEGAL). mc_ctrl consumes it in DECODE and in the class-dependent states.

## Test plan
- addu $3,$1,$2 (0x00221821), mem_ready always 1 → FETCH/DECODE/EXEC_R/WB_ALU; reg_write=1 with reg_dst=1 in cycle 4; retired=1.
- lw (0x8C220004), mem_ready delayed 3 cycles in MEM_RD → mem_req/mem_sel=1 held stable for 4 cycles; WB_MEM has mem_to_reg=1; total 8 cycles.
- beq, once with alu_zero=1 and once with alu_zero=0 → pc_write=1 with pc_src=1 only when taken; 3 cycles each; retired +1 each.
- jal (0x0C000010) → JUMP cycle shows pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2.
- Opcode 0x3F, then a special with funct 0x2A → TRAP, illegal=1 sticky, mem_req=0 forever, retired unchanged; rst_n pulse clears illegal.
- rst_n low during MEM_WR wait → mem_req falls in the same cycle; after release, FETCH with retired=0.
